sobel_window_sequencer: RTL and testbench
=========================================

Name: sobel_window_sequencer

Overview:
- Sits between the RGB444 pixel source and the Sobel filter datapath.
- Accepts a raster-order pixel stream for one frame and holds two line buffers. From them it builds the 3x3 neighbourhood for every pixel and emits it as the filter's 108-bit window word.
- Runs a frame state machine with a flush phase, zero-fills out-of-frame neighbours, and delays a valid/last flag to line up with the filter's 4-cycle output latency.

Parameters:
- IMG_W, 160, pixels per line (>=3)
- IMG_H, 120, lines per frame (>=2)
- FILT_LAT, 4, clock cycles from color_data sampled to filter_rgb_out valid

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low; clears all state when 0 at a rising edge
- start  input  1  one-cycle pulse; begins a frame when idle, ignored otherwise
- pix_in  input  12  RGB444 pixel, [11:8]=R [7:4]=G [3:0]=B
- pix_valid  input  1  pix_in is offered this cycle
- pix_ready  output  1  sequencer accepts pix_in; a transfer happens when pix_valid&pix_ready
- color_data  output  108  window to filter: [107:96]=centre [95:84]=left [83:72]=right [71:60]=up [59:48]=down [47:36]=upleft [35:24]=upright [23:12]=downleft [11:0]=downright
- win_valid  output  1  color_data holds a new window this cycle
- filt_valid  output  1  filter_rgb_out holds a result this cycle (win_valid delayed FILT_LAT)
- filt_last  output  1  with filt_valid, marks the result for pixel (IMG_H-1, IMG_W-1)
- busy  output  1  high from accepted start until frame_done
- frame_done  output  1  one-cycle pulse after the last window is issued

Behaviour:
- Reset values: pix_ready=0, color_data=0, win_valid=0, filt_valid=0, filt_last=0, busy=0, frame_done=0. The state machine goes to IDLE and the line-buffer write pointer and counters clear. Line-buffer contents are don't-care.
- IDLE state:
  - start moves to RUN.
  - Counters clear: in_col, in_row, out_col, out_row, accepted count n.
  - busy rises the cycle after start is sampled.
- RUN state:
  - pix_ready=1.
  - Each transfer shifts the pixel into the window registers and line buffers and increments the counters. in_col wraps at IMG_W-1, then in_row increments.
  - No transfer means no state advance; pix_valid gaps are allowed at any position.
- Window timing:
  - The window centred on sample index k=r*IMG_W+c is complete when sample k+IMG_W+1 is accepted.
  - color_data/win_valid are registered and appear the cycle after that transfer.
  - Transfers 0..IMG_W produce no window.
- Border fill: any neighbour outside the frame is replaced by 12'h000.
  - Row -1 and row IMG_H are zero-filled.
  - At c=0, the left, upleft and downleft neighbours are zero-filled.
  - At c=IMG_W-1, the right, upright and downright neighbours are zero-filled.
  - Zero-fill is decided from out_col/out_row, never from buffer contents.
- RUN to FLUSH: occurs on the transfer of sample IMG_W*IMG_H-1.
- FLUSH state:
  - pix_ready=0.
  - Injects IMG_W+1 virtual zero samples, one per cycle with no gaps, completing the last row.
  - After the final window is issued, frame_done pulses, the state returns to IDLE and busy drops the same cycle.
- Total windows per frame: exactly IMG_W*IMG_H, in raster order.
- filt_valid/filt_last:
  - Produced by a FILT_LAT-deep shift register of {win_valid, last_window}.
  - The shift register keeps shifting in IDLE, so results drain after frame_done.
- start in any state other than IDLE: ignored.
- start and frame_done in the same cycle: start is ignored; it must be reissued in IDLE.
- Reset low mid-frame: the frame is aborted and all outputs return to reset values on the next edge. This includes the filt_valid pipeline, so no stale results are flagged.
- Counters are sized $clog2(IMG_W) and $clog2(IMG_H). Window indexing uses no arithmetic wider than the counters.

Test Plan:
- IMG_W=4, IMG_H=3, pixels 12'h001..12'h00C with pix_valid held high -> first win_valid 1 cycle after transfer 5. Window at (0,0) = centre 001, right 002, down 005, downright 006, all other neighbours 000.
- Same frame, window at (1,1): centre 006, upleft 001, up 002, upright 003, left 005, right 007, downleft 009, down 00A, downright 00B. Exactly 12 win_valid total.
- pix_valid toggling 1/0 every cycle -> same 12 windows with identical contents and order. win_valid only follows transfers, apart from the flush cycles.
- After last transfer -> pix_ready=0 for 5 flush cycles. The last window (2,3) has down, right, downright, downleft and upright = 000. frame_done pulses once and busy falls the same cycle.
- filt_valid mirrors win_valid delayed exactly 4 cycles. filt_last is high on exactly one cycle, with the 12th filt_valid.
- Reset low after 7 transfers -> all outputs 0 on the next edge, no filt_valid afterwards. A new start then produces a clean 12-window frame.

Source files
------------

// File: rtl/sobel_window_sequencer.sv
// Sobel window sequencer: turns a raster RGB444 pixel stream into 3x3
// neighbourhood words for the Sobel datapath, with two line buffers,
// zero-filled frame borders, an end-of-frame flush and a valid/last
// pipeline aligned to the filter latency.
module sobel_window_sequencer #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int FILT_LAT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [11:0]  pix_in,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [107:0] color_data,
  output logic         win_valid,
  output logic         filt_valid,
  output logic         filt_last,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = $clog2(IMG_W + 2);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // control state
  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       in_col_q, in_col_d;
  logic [RW-1:0]       in_row_q, in_row_d;
  logic [CW-1:0]       out_col_q, out_col_d;
  logic [RW-1:0]       out_row_q, out_row_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [CW-1:0]       wp_q, wp_d;
  logic                busy_q, busy_d;
  logic                frame_done_q, frame_done_d;
  logic                win_valid_q, win_valid_d;
  logic                last_q, last_d;
  logic [107:0]        color_data_q, color_data_d;
  logic [FILT_LAT-1:0] fv_q, fv_d;
  logic [FILT_LAT-1:0] fl_q, fl_d;

  // datapath state: two previous columns for each of the three window rows
  logic [11:0] b1_q, b1_d, b2_q, b2_d;
  logic [11:0] m1_q, m1_d, m2_q, m2_d;
  logic [11:0] t1_q, t1_d, t2_q, t2_d;

  // line buffers: lb_a delays the stream by one line, lb_b by two
  logic [11:0] lb_a [IMG_W];
  logic [11:0] lb_b [IMG_W];

  logic [11:0] m_tap, t_tap, sample;
  logic        adv, emit;
  logic        top_ok, bot_ok, left_ok, right_ok;

  function automatic logic [11:0] fill(input logic [11:0] v, input logic ok);
    return ok ? v : 12'h000;
  endfunction

  assign m_tap = lb_a[wp_q];
  assign t_tap = lb_b[wp_q];

  // Border masks come from the output position only, so stale buffer data never leaks
  assign top_ok   = (out_row_q != '0);
  assign bot_ok   = (out_row_q != ROW_LAST);
  assign left_ok  = (out_col_q != '0);
  assign right_ok = (out_col_q != COL_LAST);

  // Frame FSM, counters, window assembly and filter-latency pipeline
  always_comb begin
    state_d      = state_q;
    in_col_d     = in_col_q;
    in_row_d     = in_row_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    fcnt_d       = fcnt_q;
    wp_d         = wp_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    win_valid_d  = 1'b0;
    last_d       = 1'b0;
    color_data_d = color_data_q;
    b1_d = b1_q; b2_d = b2_q;
    m1_d = m1_q; m2_d = m2_q;
    t1_d = t1_q; t2_d = t2_q;
    adv    = 1'b0;
    emit   = 1'b0;
    sample = 12'h000;

    case (state_q)
      S_IDLE: begin
        in_col_d  = '0;
        in_row_d  = '0;
        out_col_d = '0;
        out_row_d = '0;
        fcnt_d    = '0;
        wp_d      = '0;
        // a start coinciding with frame_done belongs to the old frame and is dropped
        if (start && !frame_done_q) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (pix_valid) begin
          adv    = 1'b1;
          sample = pix_in;
          // the first IMG_W+1 samples only prime the buffers
          emit   = (in_row_q != '0) && !((in_row_q == ROW_ONE) && (in_col_q == '0));
          if (in_col_q == COL_LAST) begin
            in_col_d = '0;
            if (in_row_q == ROW_LAST) begin
              state_d = S_FLUSH;
              fcnt_d  = '0;
            end else begin
              in_row_d = in_row_q + 1'b1;
            end
          end else begin
            in_col_d = in_col_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // virtual zero samples push out the windows of the last line
        adv  = 1'b1;
        emit = 1'b1;
        if (fcnt_q == FL_LAST) begin
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          frame_done_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      b2_d = b1_q; b1_d = sample;
      m2_d = m1_q; m1_d = m_tap;
      t2_d = t1_q; t1_d = t_tap;
      wp_d = (wp_q == COL_LAST) ? '0 : wp_q + 1'b1;
    end

    if (emit) begin
      win_valid_d  = 1'b1;
      last_d       = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);
      color_data_d = {m1_q,
                      fill(m2_q,  left_ok),
                      fill(m_tap, right_ok),
                      fill(t1_q,  top_ok),
                      fill(b1_q,  bot_ok),
                      fill(t2_q,  top_ok && left_ok),
                      fill(t_tap, top_ok && right_ok),
                      fill(b2_q,  bot_ok && left_ok),
                      fill(sample, bot_ok && right_ok)};
      if (out_col_q == COL_LAST) begin
        out_col_d = '0;
        out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
      end else begin
        out_col_d = out_col_q + 1'b1;
      end
    end

    fv_d = FILT_LAT'({fv_q, win_valid_q});
    fl_d = FILT_LAT'({fl_q, win_valid_q & last_q});
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      in_col_q     <= '0;
      in_row_q     <= '0;
      out_col_q    <= '0;
      out_row_q    <= '0;
      fcnt_q       <= '0;
      wp_q         <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      win_valid_q  <= 1'b0;
      last_q       <= 1'b0;
      color_data_q <= '0;
      fv_q         <= '0;
      fl_q         <= '0;
    end else begin
      state_q      <= state_d;
      in_col_q     <= in_col_d;
      in_row_q     <= in_row_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      fcnt_q       <= fcnt_d;
      wp_q         <= wp_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      win_valid_q  <= win_valid_d;
      last_q       <= last_d;
      color_data_q <= color_data_d;
      fv_q         <= fv_d;
      fl_q         <= fl_d;
    end
  end

  // Window column registers and line buffers; contents are masked, so no reset
  always_ff @(posedge clk) begin
    b1_q <= b1_d; b2_q <= b2_d;
    m1_q <= m1_d; m2_q <= m2_d;
    t1_q <= t1_d; t2_q <= t2_d;
    if (adv) begin
      lb_a[wp_q] <= sample;
      lb_b[wp_q] <= m_tap;
    end
  end

  assign pix_ready  = (state_q == S_RUN);
  assign color_data = color_data_q;
  assign win_valid  = win_valid_q;
  assign filt_valid = fv_q[FILT_LAT-1];
  assign filt_last  = fl_q[FILT_LAT-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_sequencer.sv
// Directed bench for sobel_window_sequencer on a 4x3 frame with pixels 001..00C.
module tb_sobel_window_sequencer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic         clk = 1'b0;
  logic         reset, start, pix_valid;
  logic [11:0]  pix_in;
  logic         pix_ready, win_valid, filt_valid, filt_last, busy, frame_done;
  logic [107:0] color_data;

  sobel_window_sequencer #(.IMG_W(W), .IMG_H(H), .FILT_LAT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .color_data(color_data), .win_valid(win_valid),
    .filt_valid(filt_valid), .filt_last(filt_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  logic [107:0] win_q[$];
  int win_cyc[$];
  int filt_cyc[$];
  int last_cyc[$];
  int done_cyc[$];
  int flush_cnt;
  int busy_at_done;
  int xfer_cyc[N];

  always @(negedge clk) begin
    if (win_valid) begin
      win_q.push_back(color_data);
      win_cyc.push_back(cyc);
    end
    if (filt_valid) filt_cyc.push_back(cyc);
    if (filt_last)  last_cyc.push_back(cyc);
    if (frame_done) begin
      done_cyc.push_back(cyc);
      if (busy) busy_at_done++;
    end
    if (busy && !pix_ready) flush_cnt++;
  end

  function automatic logic [11:0] px(input int r, input int c);
    if (r < 0 || r >= H || c < 0 || c >= W) return 12'h000;
    return 12'(r * W + c + 1);
  endfunction

  function automatic logic [107:0] exp_win(input int r, input int c);
    return {px(r, c), px(r, c-1), px(r, c+1), px(r-1, c), px(r+1, c),
            px(r-1, c-1), px(r-1, c+1), px(r+1, c-1), px(r+1, c+1)};
  endfunction

  task automatic clear_log();
    win_q.delete(); win_cyc.delete(); filt_cyc.delete();
    last_cyc.delete(); done_cyc.delete();
    flush_cnt = 0; busy_at_done = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offers pixels 001.. from the current negedge; returns how many transferred
  task automatic feed(input int count, input bit toggle, output int got);
    int g;
    bit ph;
    got = 0; g = 0; ph = 1'b0;
    while (got < count && g < 200) begin
      if (toggle && ph) pix_valid = 1'b0;
      else begin
        pix_valid = 1'b1;
        pix_in    = 12'(got + 1);
      end
      ph = ~ph;
      if (pix_valid && pix_ready) begin
        xfer_cyc[got] = cyc + 1;
        got++;
      end
      @(negedge clk);
      g++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input bit toggle, input bit start_at_done);
    int got, g;
    clear_log();
    pulse_start();
    total++;
    if (busy !== 1'b1) $display("FAIL busy_rise: got %b want 1", busy);
    else passed++;
    feed(N, toggle, got);
    total++;
    if (got != N) $display("FAIL xfer_count: got %0d want %0d", got, N);
    else passed++;
    g = 0;
    while (frame_done !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (frame_done !== 1'b1) $display("FAIL frame_done_timeout: got %b want 1", frame_done);
    else begin
      passed++;
      if (start_at_done) begin
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        total++;
        if (busy !== 1'b0 || pix_ready !== 1'b0)
          $display("FAIL start_at_done_ignored: busy=%b ready=%b want 0/0", busy, pix_ready);
        else passed++;
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_frame();
    total++;
    if (win_q.size() != N) $display("FAIL win_count: got %0d want %0d", win_q.size(), N);
    else passed++;
    for (int k = 0; k < win_q.size() && k < N; k++) begin
      total++;
      if (win_q[k] !== exp_win(k / W, k % W))
        $display("FAIL win_data[%0d]: got %h want %h", k, win_q[k], exp_win(k / W, k % W));
      else passed++;
    end
    for (int k = 0; k < win_cyc.size() && k < N; k++) begin
      total++;
      if (k < N - W - 1) begin
        if (win_cyc[k] != xfer_cyc[k + W + 1])
          $display("FAIL win_timing[%0d]: got cycle %0d want %0d", k, win_cyc[k], xfer_cyc[k + W + 1]);
        else passed++;
      end else begin
        if (win_cyc[k] != xfer_cyc[N - 1] + (k - (N - W - 2)))
          $display("FAIL flush_timing[%0d]: got cycle %0d want %0d", k, win_cyc[k],
                   xfer_cyc[N - 1] + (k - (N - W - 2)));
        else passed++;
      end
    end
    total++;
    if (filt_cyc.size() != N) $display("FAIL filt_count: got %0d want %0d", filt_cyc.size(), N);
    else passed++;
    for (int k = 0; k < filt_cyc.size() && k < win_cyc.size(); k++) begin
      total++;
      if (filt_cyc[k] != win_cyc[k] + 4)
        $display("FAIL filt_delay[%0d]: got cycle %0d want %0d", k, filt_cyc[k], win_cyc[k] + 4);
      else passed++;
    end
    total++;
    if (last_cyc.size() != 1 || filt_cyc.size() != N)
      $display("FAIL filt_last_count: got %0d want 1", last_cyc.size());
    else if (last_cyc[0] != filt_cyc[N - 1])
      $display("FAIL filt_last_pos: got cycle %0d want %0d", last_cyc[0], filt_cyc[N - 1]);
    else passed++;
    total++;
    if (done_cyc.size() != 1 || win_cyc.size() != N)
      $display("FAIL frame_done_count: got %0d want 1", done_cyc.size());
    else if (done_cyc[0] != win_cyc[N - 1])
      $display("FAIL frame_done_pos: got cycle %0d want %0d", done_cyc[0], win_cyc[N - 1]);
    else passed++;
    total++;
    if (busy_at_done != 0) $display("FAIL busy_at_done: got %0d want 0", busy_at_done);
    else passed++;
    total++;
    if (flush_cnt != W + 1) $display("FAIL flush_cycles: got %0d want %0d", flush_cnt, W + 1);
    else passed++;
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if (pix_ready !== 1'b0 || win_valid !== 1'b0 || filt_valid !== 1'b0 ||
        filt_last !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL %s_flags: got rdy=%b wv=%b fv=%b fl=%b busy=%b done=%b want all 0",
               name, pix_ready, win_valid, filt_valid, filt_last, busy, frame_done);
    else passed++;
    total++;
    if (color_data !== 108'h0) $display("FAIL %s_color_data: got %h want 0", name, color_data);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_in = 12'h000;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("idle");
  endtask

  task automatic test_stream();
    logic [107:0] w00, w11, wlast;
    w00   = 108'h001_000_002_000_005_000_000_000_006;
    w11   = 108'h006_005_007_002_00A_001_003_009_00B;
    wlast = 108'h00C_00B_000_008_000_007_000_000_000;
    run_frame(1'b0, 1'b1);
    total++;
    if (win_q.size() < 1 || win_q[0] !== w00)
      $display("FAIL win_0_0: got %h want %h", (win_q.size() > 0) ? win_q[0] : 108'h0, w00);
    else passed++;
    total++;
    if (win_q.size() < 6 || win_q[5] !== w11)
      $display("FAIL win_1_1: got %h want %h", (win_q.size() > 5) ? win_q[5] : 108'h0, w11);
    else passed++;
    total++;
    if (win_q.size() < N || win_q[N - 1] !== wlast)
      $display("FAIL win_2_3: got %h want %h", (win_q.size() >= N) ? win_q[N - 1] : 108'h0, wlast);
    else passed++;
    check_frame();
  endtask

  task automatic test_gaps();
    run_frame(1'b1, 1'b0);
    check_frame();
  endtask

  task automatic test_midframe_reset();
    int got;
    clear_log();
    pulse_start();
    feed(7, 1'b0, got);
    total++;
    if (got != 7) $display("FAIL partial_xfer: got %0d want 7", got);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("abort");
    clear_log();
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    total++;
    if (filt_cyc.size() != 0 || win_q.size() != 0)
      $display("FAIL abort_stale: got filt=%0d win=%0d want 0/0", filt_cyc.size(), win_q.size());
    else passed++;
    run_frame(1'b0, 1'b0);
    check_frame();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_gaps();
    test_midframe_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
